ahb3lite_sram_ws: RTL and testbench
===================================

# ahb3lite_sram_ws

Parametrised AHB3-Lite SRAM slave: the next generation of the single-port AHB SRAM, generalised in data width, depth and response timing. It adds programmable wait states, byte-lane writes for every legal HSIZE, and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers. It sits on the AHB3-Lite slave side behind the address decoder, in place of the fixed SRAM.

## Interface
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width; power of two, 8..128.
- MEM_DEPTH, 256, memory size in HDATA_SIZE-bit words; power of two. The byte range is 0..MEM_DEPTH*HDATA_SIZE/8-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase, 0..15.
- HCLK  in  1  bus clock; all logic is rising-edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, valid in the data phase.
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2**HSIZE bytes.
- HBURST  in  3  burst type; ignored. Each beat is decoded independently.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  in  1  bus ready, shared by all slaves.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Accept:** a transfer is accepted on a rising edge where HSEL && HREADY && HTRANS[1]. IDLE, BUSY and unselected cycles cause no data phase and return a zero-wait OKAY.
- **Error check at accept:**
  - out-of-range: any HADDR bit at or above log2(MEM_DEPTH*HDATA_SIZE/8) is set;
  - oversized: 2**HSIZE > HDATA_SIZE/8;
  - misaligned: HADDR is not a multiple of 2**HSIZE.
  - Any one of these makes the transfer an error transfer.
- **Registered at accept:** word index HADDR[log2(HDATA_SIZE/8) +: log2(MEM_DEPTH)], byte offset, HSIZE, HWRITE and error flag.
- **Byte lanes:** little-endian. Lanes offset..offset+2**HSIZE-1 are enabled; all other lanes are untouched.
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
- **Transitions:**
  - IDLE, accepted OKAY transfer, WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - IDLE, accepted OKAY transfer, WAIT_STATES=0: the data phase completes in the next cycle; stay in IDLE.
  - WAIT: decrement each cycle; at 0, return to IDLE after the completing cycle.
  - Accepted error transfer: go to ERR1, then ERR2, then IDLE.
- **Write commit:** on the rising edge that ends an OKAY write data phase (HREADYOUT=1), the enabled lanes of HWDATA are written.
- **Read:** HRDATA = mem[word index] in the completing cycle of an OKAY read. HRDATA = 0 in every other cycle.
- **Errors** never write memory. HRDATA = 0 during ERR1 and ERR2.
- **Back-to-back:** a read whose address phase overlaps a write's data phase to the same word returns the newly written data.
- **Reset:** memory contents are not reset. Reset mid data phase aborts the transfer with no write.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0.
- **OKAY data phase:** WAIT_STATES cycles with HREADYOUT=0, HRESP=0, then 1 cycle with HREADYOUT=1.
  - Zero-wait back-to-back throughput: 1 transfer per cycle.
- **ERROR data phase:**
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - WAIT_STATES does not apply.
- **Next address phase:** a new address phase is sampled only when HREADY=1. While this slave stalls, HREADY is low, so the next transfer is held.
- **ERR1 cancellation:** if the master drives IDLE during ERR1, nothing further is accepted.
- **Counter:** 4 bits wide. WAIT_STATES=15 gives exactly 15 stall cycles.

## Test plan
- **Reset:** assert HRESET mid write with WAIT_STATES=2 → outputs return to reset values immediately; reading that word later returns its pre-write value.
- **Zero-wait word:** WAIT_STATES=0, write 0xCAFE_DADA to 0x010, then read 0x010 back-to-back → HREADYOUT stays 1 and HRDATA=0xCAFE_DADA in the read data phase.
- **Byte/halfword:**
  - Setup: 0x1122_3344 at 0x020.
  - Byte write 0xAA to 0x021 (HWDATA=0x0000_AA00), then read 0x020 → 0x1122_AA44.
  - Halfword write 0xBEEF to 0x022 (HWDATA=0xBEEF_0000), then read 0x020 → 0xBEEF_AA44.
- **Wait states:** WAIT_STATES=3, read 0x040 → exactly 3 cycles of HREADYOUT=0 before completion; a following NONSEQ is not accepted until HREADY=1.
- **Errors** (DEPTH=256, 32-bit; each → ERR1 then ERR2, no memory change):
  - write to 0x400 (out-of-range);
  - word read at 0x002 (misaligned);
  - HSIZE=3 (oversized).
- **Idle/busy:** IDLE and BUSY cycles with HSEL=1 → HREADYOUT=1, HRESP=0, HRDATA=0, no write.

Source files
------------

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with programmable wait states, byte-lane writes and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb3lite_sram_ws #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES   = HDATA_SIZE / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int OFF_WR  = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int RANGE_W = OFF_W + IDX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  function automatic logic [BYTES-1:0] lane_mask(input logic [OFF_WR-1:0] off,
                                                 input logic [2:0]        size);
    logic [BYTES-1:0] m;
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (32'sd1 << size);
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  function automatic logic [HDATA_SIZE-1:0] merge_lanes(input logic [HDATA_SIZE-1:0] old_word,
                                                        input logic [HDATA_SIZE-1:0] new_word,
                                                        input logic [BYTES-1:0]      mask);
    logic [HDATA_SIZE-1:0] w;
    for (int i = 0; i < BYTES; i++) begin
      w[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return w;
  endfunction

  logic [HDATA_SIZE-1:0] mem_r [MEM_DEPTH];

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic                  dp_r;
  logic                  write_r;
  logic [IDX_W-1:0]      idx_r;
  logic [OFF_WR-1:0]     off_r;
  logic [2:0]            size_r;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic [HDATA_SIZE-1:0] hrdata_r;

  logic                  accept_s;
  logic                  err_s;
  logic [HADDR_SIZE-1:0] size_mask_s;
  logic [IDX_W-1:0]      idx_s;
  logic [OFF_WR-1:0]     off_s;
  logic                  commit_s;
  logic [BYTES-1:0]      commit_mask_s;
  logic [HDATA_SIZE-1:0] fwd_rdata_s;
  logic                  unused_s;

  assign accept_s    = HSEL & HREADY & HTRANS[1];
  assign size_mask_s = ~({HADDR_SIZE{1'b1}} << HSIZE);
  assign err_s       = (|(HADDR >> RANGE_W)) | (HSIZE > 3'(OFF_W)) | (|(HADDR & size_mask_s));
  assign idx_s       = HADDR[OFF_W +: IDX_W];
  assign off_s       = OFF_WR'(HADDR & HADDR_SIZE'(BYTES - 1));

  // The completing cycle of an OKAY write commits its lanes at the closing edge.
  assign commit_s      = dp_r & hreadyout_r & write_r;
  assign commit_mask_s = lane_mask(off_r, size_r);
  assign fwd_rdata_s   = (commit_s && (idx_r == idx_s))
                       ? merge_lanes(mem_r[idx_s], HWDATA, commit_mask_s)
                       : mem_r[idx_s];

  assign unused_s = ^{HBURST, HPROT, HTRANS[0]};

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;
  assign HRDATA    = hrdata_r;

  // Memory array: byte-lane writes, contents survive reset.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (commit_mask_s[i]) begin
          mem_r[idx_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered bus responses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      dp_r        <= 1'b0;
      write_r     <= 1'b0;
      idx_r       <= '0;
      off_r       <= '0;
      size_r      <= 3'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hrdata_r    <= '0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          hresp_r <= 1'b0;
          if (cnt_r == 4'd0) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hrdata_r    <= write_r ? '0 : mem_r[idx_r];
          end else begin
            cnt_r       <= cnt_r - 4'd1;
            hreadyout_r <= 1'b0;
            hrdata_r    <= '0;
          end
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          dp_r        <= 1'b0;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
          hrdata_r    <= '0;
        end
        ST_IDLE, ST_ERR2: begin
          if (accept_s) begin
            idx_r   <= idx_s;
            off_r   <= off_s;
            size_r  <= HSIZE;
            write_r <= HWRITE;
            if (err_s) begin
              state_r     <= ST_ERR1;
              dp_r        <= 1'b0;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
              hrdata_r    <= '0;
            end else if (WAIT_STATES > 0) begin
              state_r     <= ST_WAIT;
              cnt_r       <= 4'(WAIT_STATES - 1);
              dp_r        <= 1'b1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b0;
              hrdata_r    <= '0;
            end else begin
              // Zero-wait: the read result (with write forwarding) lands now.
              state_r     <= ST_IDLE;
              dp_r        <= 1'b1;
              hreadyout_r <= 1'b1;
              hresp_r     <= 1'b0;
              hrdata_r    <= HWRITE ? '0 : fwd_rdata_s;
            end
          end else begin
            state_r     <= ST_IDLE;
            dp_r        <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          dp_r        <= 1'b0;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
          hrdata_r    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) driven by a
// pipelined AHB master and compared against a byte-array reference memory.
module tb_ahb3lite_sram_ws;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        write;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } xfer_t;

  logic             hclk;
  logic [2:0]       hreset;
  logic [2:0]       hsel;
  logic [2:0][31:0] haddr;
  logic [2:0][31:0] hwdata;
  logic [2:0]       hwrite;
  logic [2:0][2:0]  hsize;
  logic [2:0][1:0]  htrans;
  wire  [2:0]       hreadyout;
  wire  [2:0]       hresp;
  wire  [2:0][31:0] hrdata;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ws [3] = '{0, 2, 3};
  logic [7:0]  ref_mem [3][1024];
  xfer_t       q [$];
  logic [31:0] last_rdata;

  ahb3lite_sram_ws #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'd0), .HPROT(4'd0),
    .HTRANS(htrans[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb3lite_sram_ws #(.WAIT_STATES(2)) u_dut1 (
    .HCLK(hclk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'd0), .HPROT(4'd0),
    .HTRANS(htrans[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  ahb3lite_sram_ws #(.WAIT_STATES(3)) u_dut2 (
    .HCLK(hclk), .HRESET(hreset[2]), .HSEL(hsel[2]), .HADDR(haddr[2]), .HWDATA(hwdata[2]),
    .HRDATA(hrdata[2]), .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HBURST(3'd0), .HPROT(4'd0),
    .HTRANS(htrans[2]), .HREADY(hreadyout[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input xfer_t x);
    int nbytes;
    nbytes = 1 << x.size;
    return (x.addr >= 32'd1024) || (nbytes > 4) || ((x.addr % nbytes) != 0);
  endfunction

  function automatic logic [31:0] model_word(input int k, input bit [31:0] addr);
    int base;
    base = int'(addr & 32'h0000_03FC);
    return {ref_mem[k][base+3], ref_mem[k][base+2], ref_mem[k][base+1], ref_mem[k][base]};
  endfunction

  task automatic model_write(input int k, input xfer_t x);
    int lane;
    for (int j = 0; j < (1 << x.size); j++) begin
      lane = int'(x.addr % 4) + j;
      ref_mem[k][int'(x.addr) + j] = x.wdata[8*lane +: 8];
    end
  endtask

  function automatic xfer_t mk(input bit write, input bit [31:0] addr, input bit [2:0] size,
                               input bit [31:0] wdata);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'b10; x.write = write; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int r;
    x.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    x.trans = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r < 9) ? 2'b00 : 2'b01;
    x.write = 1'($urandom_range(0, 1));
    x.size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    x.addr  = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 5) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
    if ($urandom_range(0, 19) == 0) x.addr = x.addr | (32'd1 << $urandom_range(10, 31));
    x.wdata = $urandom();
    return x;
  endfunction

  task automatic drive_idle(input int k);
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwrite[k] = 1'b0;
    haddr[k] = 32'd0; hsize[k] = 3'd0; hwdata[k] = 32'd0;
  endtask

  // Pipelined master: runs queue q on slave k, one call per cycle at posedge+1.
  task automatic run_seq(input int k);
    xfer_t ap, dp;
    bit    ap_v, dp_v, abort, err;
    int    stalls, guard;
    ap_v = 1'b0; dp_v = 1'b0; abort = 1'b0; stalls = 0; guard = 0;
    if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
    while ((ap_v || dp_v) && !abort && guard < 20000) begin
      guard++;
      if (ap_v) begin
        hsel[k] = ap.sel; htrans[k] = ap.trans; hwrite[k] = ap.write;
        haddr[k] = ap.addr; hsize[k] = ap.size;
      end else begin
        hsel[k] = 1'b0; htrans[k] = 2'b00; hwrite[k] = 1'b0; haddr[k] = 32'd0; hsize[k] = 3'd0;
      end
      hwdata[k] = dp_v ? dp.wdata : $urandom();
      if (dp_v) begin
        err = is_err(dp);
        if (hreadyout[k]) begin
          check("stall_cycles", 32'(stalls), err ? 32'd1 : 32'(ws[k]));
          check("hresp_done", {31'd0, hresp[k]}, {31'd0, err});
          check("hrdata_done", hrdata[k], (err || dp.write) ? 32'd0 : model_word(k, dp.addr));
          if (!err && !dp.write) last_rdata = hrdata[k];
          if (!err && dp.write) model_write(k, dp);
          dp_v = 1'b0;
        end else begin
          stalls++;
          check("hresp_stall", {31'd0, hresp[k]}, {31'd0, err});
          check("hrdata_stall", hrdata[k], 32'd0);
          if (stalls > 40) begin
            check("stall_timeout", 32'(stalls), 32'(ws[k]));
            abort = 1'b1;
          end
        end
      end else begin
        check("idle_ready", {31'd0, hreadyout[k]}, 32'd1);
        check("idle_resp", {31'd0, hresp[k]}, 32'd0);
        check("idle_rdata", hrdata[k], 32'd0);
      end
      if (hreadyout[k] && !dp_v && ap_v) begin
        if (ap.sel && ap.trans[1]) begin dp = ap; dp_v = 1'b1; stalls = 0; end
        ap_v = 1'b0;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
      end
      @(posedge hclk); #1;
    end
    if (guard >= 20000) check("seq_timeout", 32'(guard), 32'd0);
    q.delete();
    drive_idle(k);
  endtask

  initial begin
    xfer_t x;
    logic [31:0] pre;
    hreset = 3'b111;
    for (int k = 0; k < 3; k++) drive_idle(k);
    @(posedge hclk); @(posedge hclk); #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", {31'd0, hreadyout[k]}, 32'd1);
      check("rst_resp", {31'd0, hresp[k]}, 32'd0);
      check("rst_rdata", hrdata[k], 32'd0);
    end
    hreset = 3'b000;
    @(posedge hclk); #1;

    // Fill every memory with random words so later reads are defined.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 256; w++) q.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom()));
      run_seq(k);
    end

    // Zero-wait write then back-to-back read.
    q.push_back(mk(1'b1, 32'h010, 3'd2, 32'hCAFE_DADA));
    q.push_back(mk(1'b0, 32'h010, 3'd2, 32'd0));
    run_seq(0);
    check("b2b_read", last_rdata, 32'hCAFE_DADA);

    // Byte and halfword lane writes.
    q.push_back(mk(1'b1, 32'h020, 3'd2, 32'h1122_3344));
    q.push_back(mk(1'b1, 32'h021, 3'd0, 32'h0000_AA00));
    q.push_back(mk(1'b0, 32'h020, 3'd2, 32'd0));
    run_seq(0);
    check("byte_write", last_rdata, 32'h1122_AA44);
    q.push_back(mk(1'b1, 32'h022, 3'd1, 32'hBEEF_0000));
    q.push_back(mk(1'b0, 32'h020, 3'd2, 32'd0));
    run_seq(0);
    check("half_write", last_rdata, 32'hBEEF_AA44);

    // Wait states with a following NONSEQ held off by HREADY.
    q.push_back(mk(1'b0, 32'h040, 3'd2, 32'd0));
    q.push_back(mk(1'b0, 32'h044, 3'd2, 32'd0));
    q.push_back(mk(1'b1, 32'h044, 3'd2, $urandom()));
    q.push_back(mk(1'b0, 32'h044, 3'd2, 32'd0));
    run_seq(2);

    // Error transfers on zero-wait and three-wait slaves, then verify untouched words.
    for (int k = 0; k < 3; k += 2) begin
      q.push_back(mk(1'b1, 32'h400, 3'd2, $urandom()));
      q.push_back(mk(1'b0, 32'h002, 3'd2, 32'd0));
      q.push_back(mk(1'b1, 32'h000, 3'd3, $urandom()));
      q.push_back(mk(1'b1, 32'h001, 3'd1, $urandom()));
      q.push_back(mk(1'b0, 32'h000, 3'd2, 32'd0));
      run_seq(k);
    end

    // IDLE and BUSY with HSEL=1 and HWRITE=1 must leave memory alone.
    x = mk(1'b1, 32'h050, 3'd2, 32'hDEAD_BEEF); x.trans = 2'b00; q.push_back(x);
    x = mk(1'b1, 32'h050, 3'd2, 32'h0BAD_F00D); x.trans = 2'b01; q.push_back(x);
    q.push_back(mk(1'b0, 32'h050, 3'd2, 32'd0));
    run_seq(1);

    // Reset in the middle of a stalled write on the two-wait slave.
    pre = model_word(1, 32'h030);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h030; hsize[1] = 3'd2;
    @(posedge hclk); #1;
    drive_idle(1);
    hwdata[1] = ~pre;
    check("rst_mid_stall", {31'd0, hreadyout[1]}, 32'd0);
    hreset[1] = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, hreadyout[1]}, 32'd1);
    check("rst_mid_resp", {31'd0, hresp[1]}, 32'd0);
    check("rst_mid_rdata", hrdata[1], 32'd0);
    @(posedge hclk); #1;
    hreset[1] = 1'b0;
    q.push_back(mk(1'b0, 32'h030, 3'd2, 32'd0));
    run_seq(1);
    check("rst_no_write", last_rdata, pre);

    // Randomized traffic on every slave.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 80; n++) q.push_back(rand_xfer());
      run_seq(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
